// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: folds E0 / F0 prefix bytes into single key events
// ({ext, brk, code}) and queues them in a small first-word-fall-through FIFO.
// A prefix that is not followed by a byte within TIMEOUT_CYCLES clocks is
// abandoned with a proto_err pulse.
module ps2_key_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       rx_done_tick,
  input  logic       key_pop,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       proto_err
);

  // Pointer / counter widths. The timer only needs to reach TIMEOUT_CYCLES-1.
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_AA = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } state_t;

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            proto_err_q, proto_err_d;
  logic            push_req;
  logic [9:0]      push_event;   // {ext, brk, code}

  // Decoder state, prefix timer and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state decode: bytes are only looked at on rx_done_tick; otherwise the
  // timer runs while a prefix is pending and abandons it on expiry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    proto_err_d = 1'b0;
    push_req    = 1'b0;
    push_event  = {2'b00, din};

    if (state_q == ST_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (rx_done_tick) begin
      // Any accepted byte restarts the prefix timer.
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (din == BYTE_E0) begin
            state_d = ST_GOT_E0;
          end else if (din == BYTE_F0) begin
            state_d = ST_GOT_F0;
          end else if ((din != BYTE_FA) && (din != BYTE_AA)) begin
            // ACK (FA) and self-test pass (AA) are keyboard chatter, not keys.
            push_req   = 1'b1;
            push_event = {2'b00, din};
          end
        end
        ST_GOT_E0: begin
          if (din == BYTE_F0) begin
            state_d = ST_GOT_E0F0;
          end else if (din == BYTE_E0) begin
            state_d = ST_GOT_E0;
          end else begin
            push_req   = 1'b1;
            push_event = {2'b10, din};
            state_d    = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          state_d = ST_IDLE;
          if ((din == BYTE_E0) || (din == BYTE_F0)) begin
            proto_err_d = 1'b1;
          end else begin
            push_req   = 1'b1;
            push_event = {2'b01, din};
          end
        end
        ST_GOT_E0F0: begin
          state_d = ST_IDLE;
          if ((din == BYTE_E0) || (din == BYTE_F0)) begin
            proto_err_d = 1'b1;
          end else begin
            push_req   = 1'b1;
            push_event = {2'b11, din};
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (timer_q == TIMER_LAST)) begin
      // Prefix waited too long for its key byte: drop it.
      state_d     = ST_IDLE;
      timer_d     = '0;
      proto_err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty;
  logic          fifo_is_full;
  logic          do_push;
  logic          do_pop;
  logic [9:0]    head_event;

  assign fifo_empty   = (count_q == '0);
  assign fifo_is_full = (count_q == FULL_COUNT);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = key_pop && !fifo_empty;
  assign do_push = push_req && (!fifo_is_full || do_pop);

  // FIFO bookkeeping: pointers wrap by width, occupancy moves by push - pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !do_push) begin
      // Event lost to a full FIFO; latched until reset.
      overflow_d = 1'b1;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= push_event;
    end
  end

  // Head of queue is shown directly; an empty FIFO presents all zeros.
  assign head_event = fifo_empty ? 10'h000 : mem_q[rd_ptr_q];

  assign key_code  = head_event[7:0];
  assign key_break = head_event[8];
  assign key_ext   = head_event[9];
  assign key_valid = !fifo_empty;
  assign fifo_full = fifo_is_full;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: a table of directed vectors, hand-written
// corner sequences, and a randomized run checked against a queue-based model.
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       rx_done_tick;
  logic       key_pop;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       fifo_full;
  logic       overflow;
  logic       proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .rx_done_tick(rx_done_tick),
    .key_pop     (key_pop),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .key_valid   (key_valid),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Events are {ext, brk, code}; prefixes are remembered as two flags.
  logic [9:0] mq[$];
  bit         m_e0, m_f0, m_ovf, m_perr;
  int         m_age;   // clock edges since the last accepted byte

  task automatic model_edge(input bit rst, input bit tick, input logic [7:0] b, input bit pop);
    bit         push;
    bit         was_full;
    logic [9:0] ev;
    push = 1'b0;
    ev   = '0;
    if (rst) begin
      mq.delete();
      m_e0 = 0; m_f0 = 0; m_age = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    m_perr = 0;
    if (tick) begin
      m_age = 0;
      if (!m_e0 && !m_f0) begin
        if (b == 8'hE0) m_e0 = 1;
        else if (b == 8'hF0) m_f0 = 1;
        else if (b != 8'hFA && b != 8'hAA) begin push = 1; ev = {2'b00, b}; end
      end else if (m_f0) begin
        if (b == 8'hE0 || b == 8'hF0) m_perr = 1;
        else begin push = 1; ev = {m_e0, 1'b1, b}; end
        m_e0 = 0; m_f0 = 0;
      end else begin
        if (b == 8'hF0) m_f0 = 1;
        else if (b != 8'hE0) begin push = 1; ev = {2'b10, b}; m_e0 = 0; end
      end
    end else if (m_e0 || m_f0) begin
      // The TO-th quiet edge after a prefix abandons it.
      m_age++;
      if (m_age == TO) begin
        m_e0 = 0; m_f0 = 0; m_age = 0; m_perr = 1;
      end
    end
    was_full = (mq.size() == DEPTH);
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (push) begin
      if (!was_full || pop) mq.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [9:0] h;
    bit         v;
    bit         bad;
    v = (mq.size() > 0);
    h = v ? mq[0] : 10'h000;
    bad = (key_valid !== v) || (key_code !== h[7:0]) || (key_ext !== h[9]) ||
          (key_break !== h[8]) || (fifo_full !== (mq.size() == DEPTH)) ||
          (overflow !== m_ovf) || (proto_err !== m_perr);
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL model_%s t=%0t got v=%0b code=%02h ext=%0b brk=%0b full=%0b ovf=%0b perr=%0b expected v=%0b code=%02h ext=%0b brk=%0b full=%0b ovf=%0b perr=%0b",
               tag, $time, key_valid, key_code, key_ext, key_break, fifo_full, overflow, proto_err,
               v, h[7:0], h[9], h[8], (mq.size() == DEPTH), m_ovf, m_perr);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock: drive after the falling edge, sample 1 time unit after rising edge.
  task automatic step(input bit rst, input bit tick, input logic [7:0] b, input bit pop, input string tag);
    @(negedge clk);
    reset = rst; rx_done_tick = tick; din = b; key_pop = pop;
    @(posedge clk);
    #1;
    model_edge(rst, tick, b, pop);
    compare_model(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, "idle");
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         tick;
    logic [7:0] b;
    bit         pop;
    logic [13:0] exp; // {valid, ext, brk, code, full, ovf, perr}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit t, logic [7:0] b, bit p, bit v, bit e, bit k,
                              logic [7:0] c, bit f, bit o, bit r);
    vec_t x;
    x.tick = t; x.b = b; x.pop = p;
    x.exp  = {v, e, k, c, f, o, r};
    return x;
  endfunction

  initial begin
    logic [13:0] got;
    int          pulses;
    int          at;
    logic [7:0]  seq5[5];
    logic [7:0]  b;

    reset = 1'b1; rx_done_tick = 1'b0; din = 8'h00; key_pop = 1'b0;

    // Reset, including a tick and pop arriving during reset.
    step(1, 1, 8'h1C, 1, "rst");
    step(1, 0, 8'h00, 0, "rst");
    chk("reset_outputs", {key_valid, key_ext, key_break, key_code, fifo_full, overflow, proto_err}, 14'h0);

    //         tick byte   pop  v  e  k  code   f  o  r
    tbl.push_back(mk(1, 8'h1C, 0, 1, 0, 0, 8'h1C, 0, 0, 0)); // make
    tbl.push_back(mk(1, 8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // pop, F0 pending
    tbl.push_back(mk(1, 8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 0)); // break
    tbl.push_back(mk(1, 8'hE0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'h75, 0, 1, 1, 0, 8'h75, 0, 0, 0)); // ext make
    tbl.push_back(mk(1, 8'hE0, 0, 1, 1, 0, 8'h75, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 1, 0, 8'h75, 0, 0, 0));
    tbl.push_back(mk(1, 8'h75, 0, 1, 1, 0, 8'h75, 0, 0, 0)); // ext break queued
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'h75, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFA, 1, 0, 0, 0, 8'h00, 0, 0, 0)); // ACK ignored
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 8'h00, 0, 0, 0)); // BAT ignored
    tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 0, 1)); // F0,E0 error
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 0, 1)); // E0,F0,F0 error
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'h1C, 1, 1, 0, 0, 8'h1C, 0, 0, 0)); // push+pop on empty
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) begin
      step(0, tbl[i].tick, tbl[i].b, tbl[i].pop, "tbl");
      got = {key_valid, key_ext, key_break, key_code, fifo_full, overflow, proto_err};
      chk($sformatf("tbl_row%0d", i), got, tbl[i].exp);
    end

    // Overflow: five makes into a four-deep FIFO, then drain.
    step(1, 0, 8'h00, 0, "rst");
    seq5[0] = 8'h15; seq5[1] = 8'h1D; seq5[2] = 8'h24; seq5[3] = 8'h2D; seq5[4] = 8'h2C;
    for (int i = 0; i < 5; i++) step(0, 1, seq5[i], 0, "ovf");
    chk("ovf_full", fifo_full, 1);
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), key_code, seq5[i]);
      step(0, 0, 8'h00, 1, "drain");
    end
    chk("ovf_empty", key_valid, 0);
    chk("ovf_still_set", overflow, 1);

    // Full FIFO with simultaneous push and pop: nothing lost.
    step(1, 0, 8'h00, 0, "rst");
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h11 + 8'(i), 0, "fill");
    step(0, 1, 8'h15, 1, "pushpop");
    chk("pp_full", fifo_full, 1);
    chk("pp_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_drain%0d", i), key_code, 8'h12 + 8'(i));
      step(0, 0, 8'h00, 1, "drain");
    end

    // Prefix timeout.
    step(1, 0, 8'h00, 0, "rst");
    step(0, 1, 8'hF0, 0, "to");
    pulses = 0; at = -1;
    for (int i = 1; i <= TO + 5; i++) begin
      step(0, 0, 8'h00, 0, "to");
      if (proto_err) begin pulses++; at = i; end
    end
    chk("to_pulses", pulses, 1);
    chk("to_edge", at, TO);
    step(0, 1, 8'h1C, 0, "to");
    chk("to_after", {key_valid, key_ext, key_break, key_code}, {3'b100, 8'h1C});

    // Byte arriving on the very edge the timer would expire: processed normally.
    step(1, 0, 8'h00, 0, "rst");
    step(0, 1, 8'hF0, 0, "edge");
    pulses = 0;
    for (int i = 1; i < TO; i++) begin
      step(0, 0, 8'h00, 0, "edge");
      if (proto_err) pulses++;
    end
    step(0, 1, 8'h1C, 0, "edge");
    if (proto_err) pulses++;
    chk("edge_no_err", pulses, 0);
    chk("edge_break", {key_valid, key_ext, key_break, key_code}, {3'b101, 8'h1C});

    // Repeated E0 restarts the timer.
    step(1, 0, 8'h00, 0, "rst");
    step(0, 1, 8'hE0, 0, "rst_e0");
    pulses = 0;
    for (int i = 0; i < TO - 2; i++) begin step(0, 0, 8'h00, 0, "e0"); if (proto_err) pulses++; end
    step(0, 1, 8'hE0, 0, "e0");
    for (int i = 0; i < TO - 2; i++) begin step(0, 0, 8'h00, 0, "e0"); if (proto_err) pulses++; end
    step(0, 1, 8'h75, 0, "e0");
    chk("e0_restart_no_err", pulses, 0);
    chk("e0_restart_event", {key_valid, key_ext, key_break, key_code}, {3'b110, 8'h75});

    // Reset between E0 and 75 discards the prefix.
    step(1, 0, 8'h00, 0, "rst");
    step(0, 1, 8'hE0, 0, "mid");
    step(1, 0, 8'h00, 0, "mid");
    chk("mid_empty", key_valid, 0);
    chk("mid_ovf", overflow, 0);
    step(0, 1, 8'h75, 0, "mid");
    chk("mid_event", {key_valid, key_ext, key_break, key_code}, {3'b100, 8'h75});

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hFA;
        3:       b = 8'hAA;
        default: b = 8'($urandom);
      endcase
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), b,
           ($urandom_range(0, 4) == 0), "rand");
      if ($urandom_range(0, 99) == 0) idle($urandom_range(TO - 3, TO + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
